shift_sched: RTL
================

SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter ARB_MODE, default 1, SHALL select arbitration: 1 = round-robin, 0 = fixed priority with port 0 winning.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port reset_n, input, 1: asynchronous active-low reset.
REQ-005 Ports req_valid_0 and req_valid_1, input, 1 each: request valid, one per port.
REQ-006 Ports req_ready_0 and req_ready_1, output, 1 each: request accepted this cycle.
REQ-007 Ports req_type_0 and req_type_1, input, 5 each: shift op; 5'h0C = SLL, 5'h0D = SRL, 5'h0E = SRA.
REQ-008 Ports req_shamt_0 and req_shamt_1, input, 5 each: shift amount, 0..31.
REQ-009 Ports req_data_0 and req_data_1, input, 32 each: operand T.
REQ-010 Ports rsp_valid_0 and rsp_valid_1, output, 1 each: result valid for that port.
REQ-011 Ports rsp_ready_0 and rsp_ready_1, input, 1 each: consumer accepts the result.
REQ-012 Port rsp_data, output, 32: shifted result Y, shared by both ports.
REQ-013 Port rsp_carry, output, 1: last bit shifted out (C).
REQ-014 Port rsp_err, output, 1: the request had an unsupported type.

Function
REQ-015 The FSM SHALL have two states: IDLE (no result held) and RESP (one result held, tagged with its owner port).
REQ-016 req_ready_x SHALL be high only when port x holds the grant and either the state is IDLE or the current owner's rsp_ready is high; other ports' req_ready SHALL be 0 that cycle.
REQ-017 A request SHALL be accepted on a cycle with req_valid_x and req_ready_x both high; its result SHALL appear at the next rising edge, giving 1-cycle latency.
REQ-018 IDLE + accept -> RESP. RESP + owner rsp_ready + no accept -> IDLE. RESP + owner rsp_ready + accept -> RESP with the new result and new owner, giving 1 result/cycle throughput.
REQ-019 In RESP, rsp_valid_x SHALL be 1 only for the owner port x.
REQ-020 rsp_data, rsp_carry and rsp_err SHALL stay stable while rsp_valid is high and rsp_ready is low.
REQ-021 Round-robin: with both ports valid, the grant SHALL go to the port not accepted most recently; the pointer SHALL update only on accept.
REQ-022 With a single port valid, that port SHALL get the grant regardless of the pointer.
REQ-023 Grant computation SHALL depend only on req_valid_x and the pointer, never on req_ready.
REQ-024 SLL, shamt n>0: Y = T<<n, C = T[32-n].
REQ-025 SRL, shamt n>0: Y = T>>n with zero fill, C = T[n-1].
REQ-026 SRA, shamt n>0: Y = T>>n with T[31] fill, C = T[n-1].
REQ-027 Any supported type with shamt 0 SHALL give Y = T and C = 0.
REQ-028 An unsupported type SHALL give Y = T, C = 0 and rsp_err = 1; it SHALL still complete the handshake normally.
REQ-029 The shift datapath SHALL be fully combinational with no latches, and every case SHALL have a defined default.

Reset
REQ-030 While reset_n = 0, outputs SHALL be: state IDLE, all rsp_valid 0, rsp_data 0, rsp_carry 0, rsp_err 0, and all req_ready 0.
REQ-031 While reset_n = 0, the round-robin pointer SHALL be set to "port 1 last", so port 0 wins the first contention.
REQ-032 Reset asserted mid-RESP SHALL drop the held result immediately, with no response delivered.

Configuration
REQ-033 Macro SHIFT_SCHED_ROT_EN defined: types 5'h03 (ROL: Y = T rotated left n, C = Y[0]) and 5'h04 (ROR: Y = T rotated right n, C = Y[31]) SHALL be supported, with C = 0 when shamt = 0.
REQ-034 Macro SHIFT_SCHED_ROT_EN undefined: types 5'h03 and 5'h04 SHALL be treated as unsupported per REQ-028.

Structure
REQ-035 Shared package mips_pkg SHALL hold the shift-type constants (SLL, SRL, SRA, ROL, ROR) and the FSM state typedef.
REQ-036 Sub-module shift_rr_arb SHALL implement the 2-port grant and pointer; the shift datapath and result register SHALL stay in shift_sched.

Verification
REQ-037 Port 0 only, SLL, shamt 4, T = 32'h8000_000F -> one cycle later rsp_valid_0 = 1, rsp_data = 32'h0000_00F0, rsp_carry = 0.
REQ-038 Port 1 only, SRA, shamt 31, T = 32'h8000_0000 -> rsp_data = 32'hFFFF_FFFF, rsp_carry = 0; with T = 32'h4000_0001 and SRL shamt 1 -> rsp_data = 32'h2000_0000, rsp_carry = 1.
REQ-039 Both ports valid continuously, both rsp_ready = 1 -> grants alternate 0,1,0,1 starting with port 0, one result per cycle.
REQ-040 rsp_ready_0 held 0 for 3 cycles in RESP -> rsp fields stable, req_ready_0 and req_ready_1 = 0; on release the result completes and the pending port 1 request is accepted the same cycle.
REQ-041 Type 5'h03, shamt 8, T = 32'h1200_0034 -> with SHIFT_SCHED_ROT_EN: rsp_data = 32'h0000_3412, rsp_err = 0; without it: rsp_data = T, rsp_err = 1.
REQ-042 reset_n pulsed low while in RESP -> all rsp_valid drop asynchronously; after release, contention is granted to port 0 first.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared shift-op encodings and scheduler state type.
// Imported by shift_sched and shift_rr_arb.
package mips_pkg;

  localparam logic [4:0] OP_SLL = 5'h0C;
  localparam logic [4:0] OP_SRL = 5'h0D;
  localparam logic [4:0] OP_SRA = 5'h0E;
  localparam logic [4:0] OP_ROL = 5'h03;
  localparam logic [4:0] OP_ROR = 5'h04;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/shift_rr_arb.sv
// Two-port grant with last-accepted pointer (ARB_MODE 1 = round-robin,
// 0 = fixed, port 0 wins). Ports: req_valid[1:0], acc_en/acc_port, gnt[1:0].
module shift_rr_arb
  import mips_pkg::*;
#(
  parameter int ARB_MODE = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  input  logic       acc_en,
  input  logic       acc_port,
  output logic [1:0] gnt
);

  // 1 = port 1 was accepted last
  logic last_q;
  logic last_d;
  logic pick0;

  always_comb begin
    pick0 = (ARB_MODE == 0) || last_q;
    gnt   = 2'b00;
    unique case (1'b1)
      (req_valid == 2'b11): gnt = pick0 ? 2'b01 : 2'b10;
      (req_valid == 2'b01): gnt = 2'b01;
      (req_valid == 2'b10): gnt = 2'b10;
      default:              gnt = 2'b00;
    endcase
    last_d = acc_en ? acc_port : last_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end

endmodule

// File: rtl/shift_sched.sv
// Two-port shift unit: arbitrated request, 1-cycle registered shared result.
// Ports: req_* / rsp_* per port, shared rsp_data/carry/err. Macro SHIFT_SCHED_ROT_EN adds ROL/ROR.
module shift_sched
  import mips_pkg::*;
#(
  parameter int ARB_MODE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [4:0]  req_type_0,
  input  logic [4:0]  req_type_1,
  input  logic [4:0]  req_shamt_0,
  input  logic [4:0]  req_shamt_1,
  input  logic [31:0] req_data_0,
  input  logic [31:0] req_data_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_err
);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] data_q, data_d;
  logic        carry_q, carry_d;
  logic        err_q, err_d;

  logic [1:0]  gnt;
  logic [1:0]  rdy;
  logic        own_rdy;
  logic        can_take;
  logic        acc_en;
  logic        acc_port;

  logic [4:0]  typ;
  logic [4:0]  n;
  logic [31:0] t;
  logic [31:0] sh_y;
  logic        sh_c;
  logic        sh_e;
  logic [32:0] w;
`ifdef SHIFT_SCHED_ROT_EN
  logic [63:0] d;
`endif

  shift_rr_arb #(
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid ({req_valid_1, req_valid_0}),
    .acc_en    (acc_en),
    .acc_port  (acc_port),
    .gnt       (gnt)
  );

  always_comb begin
    own_rdy  = owner_q ? rsp_ready_1 : rsp_ready_0;
    can_take = (state_q == S_IDLE) || own_rdy;
    // gated by reset_n so nothing is offered while in reset
    rdy      = gnt & {2{can_take & reset_n}};
    acc_en   = |(rdy & {req_valid_1, req_valid_0});
    acc_port = gnt[1];
    typ      = gnt[1] ? req_type_1  : req_type_0;
    n        = gnt[1] ? req_shamt_1 : req_shamt_0;
    t        = gnt[1] ? req_data_1  : req_data_0;
  end

  assign req_ready_0 = rdy[0];
  assign req_ready_1 = rdy[1];

  // An extra bit beside the operand catches the last bit shifted out,
  // which is naturally 0 for a zero shift amount.
  always_comb begin
    sh_y = t;
    sh_c = 1'b0;
    sh_e = 1'b1;
    w    = '0;
`ifdef SHIFT_SCHED_ROT_EN
    d    = '0;
`endif
    case (typ)
      OP_SLL: begin
        w    = {1'b0, t} << n;
        sh_y = w[31:0];
        sh_c = w[32];
        sh_e = 1'b0;
      end
      OP_SRL: begin
        w    = {t, 1'b0} >> n;
        sh_y = w[32:1];
        sh_c = w[0];
        sh_e = 1'b0;
      end
      OP_SRA: begin
        w    = $unsigned($signed({t, 1'b0}) >>> n);
        sh_y = w[32:1];
        sh_c = w[0];
        sh_e = 1'b0;
      end
`ifdef SHIFT_SCHED_ROT_EN
      OP_ROL: begin
        d    = {t, t} << n;
        sh_y = d[63:32];
        sh_c = (n != 5'd0) & d[32];
        sh_e = 1'b0;
      end
      OP_ROR: begin
        d    = {t, t} >> n;
        sh_y = d[31:0];
        sh_c = (n != 5'd0) & d[31];
        sh_e = 1'b0;
      end
`endif
      default: begin
        sh_y = t;
        sh_c = 1'b0;
        sh_e = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    data_d  = data_q;
    carry_d = carry_q;
    err_d   = err_q;
    if (acc_en) begin
      state_d = S_RESP;
      owner_d = acc_port;
      data_d  = sh_y;
      carry_d = sh_c;
      err_d   = sh_e;
    end else if (state_q == S_RESP && own_rdy) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid_0 = (state_q == S_RESP) && !owner_q;
  assign rsp_valid_1 = (state_q == S_RESP) &&  owner_q;
  assign rsp_data    = data_q;
  assign rsp_carry   = carry_q;
  assign rsp_err     = err_q;

endmodule
